// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the fetch stage
//
// Purpose: fetch FSM state encoding, default reset PC and instruction word size.
// Ports:   none (package).

package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] WORD_BYTES       = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - prefetch FIFO holding {instr, pc+4}
//
// Purpose: synchronous FIFO with registered storage; head is read directly from storage.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   flush             empty the FIFO; wins over push and pop
//   head_data         current head entry
//   head_valid        FIFO not empty
//   count             number of stored entries

module instruction_fetch_unit_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push    = push && (count != FULL_COUNT);
   assign do_pop     = pop && (count != '0);
   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

   // Storage is reset too so that every output reads 0 straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage feeding the IF/ID register
//
// Purpose: owns the fetch PC, issues one outstanding word read at a time, buffers
//          returned words with their PC+4 in a prefetch FIFO, handles redirects.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stall_i                    IF/ID not accepting; head entry held
//   redirect_i, redirect_pc_i  one-cycle redirect pulse and its target
//   imem_req_o, imem_addr_o    read request and word-aligned address
//   imem_ready_i               memory accepts the request this cycle
//   imem_rvalid_i, imem_rdata_i read response
//   instr_valid_o, instr_o, pc_plus_4_o  FIFO head toward decode

module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus_4_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t state, state_nx;
   logic [31:0]  fetch_pc, fetch_pc_nx;
   logic [31:0]  inflight_pc, inflight_pc_nx;
   logic [31:0]  redirect_target;
   logic         fifo_push;
   logic         fifo_pop;
   logic [CW-1:0] fifo_count;
   logic         fifo_has_space;
   logic [63:0]  head_data;

   assign redirect_target = redirect_pc_i & ~32'h0000_0003;
   assign fifo_has_space  = (fifo_count < CW'(FIFO_DEPTH));
   assign fifo_pop        = instr_valid_o && !stall_i && !redirect_i;

   assign imem_req_o  = (state == REQ);
   assign imem_addr_o = fetch_pc;
   assign instr_o     = head_data[63:32];
   assign pc_plus_4_o = head_data[31:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
      end else begin
         state       <= state_nx;
         fetch_pc    <= fetch_pc_nx;
         inflight_pc <= inflight_pc_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      fetch_pc_nx    = fetch_pc;
      inflight_pc_nx = inflight_pc;
      fifo_push      = 1'b0;
      case (state)
         // Only request when a slot is free, so the response can always be pushed.
         IDLE: begin
            if (!redirect_i && fifo_has_space) state_nx = REQ;
         end
         // An accepted request must still be drained even if a redirect arrives with it.
         REQ: begin
            if (imem_ready_i) begin
               state_nx       = redirect_i ? DROP : WAIT;
               inflight_pc_nx = fetch_pc;
               fetch_pc_nx    = fetch_pc + WORD_BYTES;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               state_nx = imem_rvalid_i ? IDLE : DROP;
            end else if (imem_rvalid_i) begin
               fifo_push = 1'b1;
               state_nx  = IDLE;
            end
         end
         DROP: begin
            if (imem_rvalid_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Redirect overrides any PC update made above.
      if (redirect_i) fetch_pc_nx = redirect_target;
   end

   instruction_fetch_unit_fetch_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_data  ({imem_rdata_i, inflight_pc + WORD_BYTES}),
      .pop        (fifo_pop),
      .flush      (redirect_i),
      .head_data  (head_data),
      .head_valid (instr_valid_o),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_plus_4_o;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          lat      = 1;
   int          wait_cnt = 0;
   logic [31:0] pend_data;
   logic        acc_s;
   logic [31:0] addr_s;
   logic [31:0] acc_q[$];
   int          acc_cyc[$];
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instruction_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_plus_4_o   (pc_plus_4_o)
   );

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_acc(input int n, input string nm);
      int k = 0;
      while (acc_q.size() < n && k < 100) begin
         step();
         k++;
      end
      check32(nm, acc_q.size(), n);
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         step();
         k++;
      end
      check32(nm, sb_q.size(), 0);
   endtask

   task automatic expect_entry(input logic [31:0] ins, input logic [31:0] pc4);
      sb_q.push_back({ins, pc4});
   endtask

   // Memory model: response data is the address inverted, delivered lat cycles after acceptance.
   initial begin : mem_model
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         acc_s  = imem_req_o && imem_ready_i && !reset;
         addr_s = imem_addr_o;
         @(posedge clk);
         #1;
         imem_rvalid_i = 1'b0;
         if (acc_s) begin
            acc_q.push_back(addr_s);
            acc_cyc.push_back(cyc);
            pend_data = addr_s ^ 32'hFFFF_FFFF;
            wait_cnt  = lat;
         end
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = pend_data;
            end
         end
      end
   end

   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!reset && instr_valid_o && !stall_i && !redirect_i) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual=%h/%h expected=none", instr_o, pc_plus_4_o);
            end else begin
               e = sb_q.pop_front();
               check32("sb_instr", instr_o, e[63:32]);
               check32("sb_pc4", pc_plus_4_o, e[31:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset         = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      imem_ready_i  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("rst_req", imem_req_o, 0);
      check32("rst_addr", imem_addr_o, 32'h0040_0000);
      check32("rst_valid", instr_valid_o, 0);
      check32("rst_instr", instr_o, 0);
      check32("rst_pc4", pc_plus_4_o, 0);

      // Test 1: sequential fetch, 0-wait memory
      imem_ready_i = 1'b1;
      lat = 1;
      expect_entry(32'hFFBF_FFFF, 32'h0040_0004);
      expect_entry(32'hFFBF_FFFB, 32'h0040_0008);
      expect_entry(32'hFFBF_FFF7, 32'h0040_000C);
      step();
      reset = 1'b0;
      wait_acc(3, "t1_acc");
      imem_ready_i = 1'b0;
      check32("t1_addr0", acc_q[0], 32'h0040_0000);
      check32("t1_addr1", acc_q[1], 32'h0040_0004);
      check32("t1_addr2", acc_q[2], 32'h0040_0008);
      check32("t1_gap0", acc_cyc[1] - acc_cyc[0], 3);
      check32("t1_gap1", acc_cyc[2] - acc_cyc[1], 3);
      drain("t1_drain");

      // Test 2: stall fills the FIFO, no further requests, in-order release
      stall_i = 1'b1;
      imem_ready_i = 1'b1;
      expect_entry(32'hFFBF_FFF3, 32'h0040_0010);
      expect_entry(32'hFFBF_FFEF, 32'h0040_0014);
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i >= 7) check32("t2_no_req", imem_req_o, 0);
      end
      check32("t2_acc", acc_q.size(), 5);
      check32("t2_head_valid", instr_valid_o, 1);
      check32("t2_head_instr", instr_o, 32'hFFBF_FFF3);
      check32("t2_head_pc4", pc_plus_4_o, 32'h0040_0010);
      imem_ready_i = 1'b0;
      stall_i = 1'b0;
      drain("t2_drain");

      // Test 3: redirect in WAIT, late response dropped
      lat = 4;
      imem_ready_i = 1'b1;
      wait_acc(6, "t3_acc_old");
      check32("t3_old_addr", acc_q[5], 32'h0040_0014);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0040_0103;
      lat = 1;
      expect_entry(32'hFFBF_FEFF, 32'h0040_0104);
      step();
      redirect_i = 1'b0;
      wait_acc(7, "t3_acc_new");
      imem_ready_i = 1'b0;
      check32("t3_new_addr", acc_q[6], 32'h0040_0100);
      drain("t3_drain");

      // Test 4: redirect coincident with rvalid
      lat = 2;
      imem_ready_i = 1'b1;
      wait_acc(8, "t4_acc_old");
      lat = 1;
      check32("t4_old_addr", acc_q[7], 32'h0040_0104);
      for (int k = 0; k < 10 && !imem_rvalid_i; k++) step();
      check32("t4_rvalid_seen", imem_rvalid_i, 1);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0040_1000;
      expect_entry(32'hFFBF_EFFF, 32'h0040_1004);
      step();
      redirect_i = 1'b0;
      check32("t4_empty_next", instr_valid_o, 0);
      wait_acc(9, "t4_acc_new");
      imem_ready_i = 1'b0;
      check32("t4_new_addr", acc_q[8], 32'h0040_1000);
      drain("t4_drain");

      // Test 5: redirect while REQ is held off by ready=0
      repeat (4) step();
      check32("t5_req_before", imem_req_o, 1);
      check32("t5_addr_before", imem_addr_o, 32'h0040_1004);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0050_0000;
      step();
      redirect_i = 1'b0;
      check32("t5_req_after", imem_req_o, 1);
      check32("t5_addr_after", imem_addr_o, 32'h0050_0000);
      repeat (2) step();
      lat = 1;
      expect_entry(32'hFFAF_FFFF, 32'h0050_0004);
      imem_ready_i = 1'b1;
      wait_acc(10, "t5_acc");
      imem_ready_i = 1'b0;
      check32("t5_addr", acc_q[9], 32'h0050_0000);
      repeat (6) step();
      check32("t5_one_acc", acc_q.size(), 10);
      drain("t5_drain");

      // Test 6: PC wrap, then reset mid-WAIT
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      step();
      redirect_i = 1'b0;
      expect_entry(32'h0000_0003, 32'h0000_0000);
      imem_ready_i = 1'b1;
      wait_acc(11, "t6_acc_wrap");
      imem_ready_i = 1'b0;
      check32("t6_wrap_addr", acc_q[10], 32'hFFFF_FFFC);
      drain("t6_drain");
      repeat (2) step();
      check32("t6_req_zero", imem_req_o, 1);
      check32("t6_addr_zero", imem_addr_o, 32'h0000_0000);
      stall_i = 1'b1;
      imem_ready_i = 1'b1;
      wait_acc(12, "t6_acc_zero");
      lat = 6;
      wait_acc(13, "t6_acc_four");
      imem_ready_i = 1'b0;
      check32("t6_zero_addr", acc_q[11], 32'h0000_0000);
      check32("t6_four_addr", acc_q[12], 32'h0000_0004);
      step();
      check32("t6_head_valid", instr_valid_o, 1);
      check32("t6_head_instr", instr_o, 32'hFFFF_FFFF);
      check32("t6_head_pc4", pc_plus_4_o, 32'h0000_0004);
      reset = 1'b1;
      #1;
      check32("t6_rst_req", imem_req_o, 0);
      check32("t6_rst_valid", instr_valid_o, 0);
      check32("t6_rst_instr", instr_o, 0);
      check32("t6_rst_pc4", pc_plus_4_o, 0);
      check32("t6_rst_addr", imem_addr_o, 32'h0040_0000);
      step();
      step();
      reset = 1'b0;
      stall_i = 1'b0;
      for (int k = 0; k < 20 && wait_cnt != 0; k++) step();
      check32("t6_stale_delivered", wait_cnt, 0);
      repeat (2) step();
      check32("t6_stale_ignored", instr_valid_o, 0);
      check32("t6_restart_req", imem_req_o, 1);
      check32("t6_restart_addr", imem_addr_o, 32'h0040_0000);
      lat = 1;
      expect_entry(32'hFFBF_FFFF, 32'h0040_0004);
      imem_ready_i = 1'b1;
      wait_acc(14, "t6_acc_restart");
      imem_ready_i = 1'b0;
      check32("t6_restart_acc_addr", acc_q[13], 32'h0040_0000);
      drain("t6_drain_restart");

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
